// File: rtl/ex_muldiv.sv
// Iterative RV32M multiply/divide unit for the EX stage.
// Radix-2 shift-add multiply, restoring divide, early-out for div-by-zero and signed overflow.
module ex_muldiv #(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  start_in,
    input  logic [2:0]            op_in,
    input  logic [XLEN-1:0]       rs1_val_in,
    input  logic [XLEN-1:0]       rs2_val_in,
    input  logic                  rd_in,
    input  logic [REG_ADDR_W-1:0] rd_addr_in,
    input  logic                  flush_in,
    output logic                  stallreq_out,
    output logic                  done_out,
    output logic                  rd_out,
    output logic [REG_ADDR_W-1:0] rd_addr_out,
    output logic [XLEN-1:0]       rd_val_out
);
    localparam int CW = $clog2(XLEN);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    logic [1:0]            state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [2:0]            op_q, op_d;
    logic                  rd_en_q, rd_en_d;
    logic [REG_ADDR_W-1:0] addr_q, addr_d;
    logic                  neg_q, neg_d;
    logic [XLEN-1:0]       opnd_q, opnd_d;
    logic [2*XLEN-1:0]     acc_q, acc_d;
    logic                  done_q, done_d;
    logic                  rd_q, rd_d;
    logic [REG_ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [XLEN-1:0]       rd_val_q, rd_val_d;

    // Operand decode in IDLE: magnitudes, result sign and early-out detection
    logic            is_div, a_signed, b_signed, sa, sb, neg_in, div_zero, div_ovf;
    logic [XLEN-1:0] mag_a, mag_b, early_val;

    always_comb begin
        is_div    = op_in[2];
        a_signed  = (op_in == 3'd1) || (op_in == 3'd2) || (op_in == 3'd4) || (op_in == 3'd6);
        b_signed  = (op_in == 3'd1) || (op_in == 3'd4) || (op_in == 3'd6);
        sa        = a_signed & rs1_val_in[XLEN-1];
        sb        = b_signed & rs2_val_in[XLEN-1];
        mag_a     = sa ? -rs1_val_in : rs1_val_in;
        mag_b     = sb ? -rs2_val_in : rs2_val_in;
        neg_in    = (is_div && op_in[1]) ? sa : (sa ^ sb);
        div_zero  = is_div && (rs2_val_in == '0);
        div_ovf   = (op_in == 3'd4 || op_in == 3'd6) && (rs1_val_in == MIN_NEG) && (rs2_val_in == '1);
        if (div_zero)
            early_val = op_in[1] ? rs1_val_in : '1;
        else
            early_val = op_in[1] ? '0 : MIN_NEG;
    end

    // One iteration: multiply shifts the multiplier out of acc[0]; divide shifts the dividend in
    logic [XLEN:0]     mul_sum, rem_sh, diff;
    logic [2*XLEN-1:0] mul_next, div_next, acc_nx, prod_s;
    logic [XLEN-1:0]   quo_s, rem_s, final_val;

    always_comb begin
        mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        mul_next = {mul_sum, acc_q[XLEN-1:1]};
        rem_sh   = acc_q[2*XLEN-1:XLEN-1];
        diff     = rem_sh - {1'b0, opnd_q};
        if (diff[XLEN])
            div_next = {rem_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
        else
            div_next = {diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
        acc_nx = op_q[2] ? div_next : mul_next;
        prod_s = neg_q ? -acc_nx : acc_nx;
        quo_s  = neg_q ? -acc_nx[XLEN-1:0] : acc_nx[XLEN-1:0];
        rem_s  = neg_q ? -acc_nx[2*XLEN-1:XLEN] : acc_nx[2*XLEN-1:XLEN];
        case (op_q)
            3'd0:             final_val = prod_s[XLEN-1:0];
            3'd1, 3'd2, 3'd3: final_val = prod_s[2*XLEN-1:XLEN];
            3'd4, 3'd5:       final_val = quo_s;
            default:          final_val = rem_s;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        rd_en_d   = rd_en_q;
        addr_d    = addr_q;
        neg_d     = neg_q;
        opnd_d    = opnd_q;
        acc_d     = acc_q;
        done_d    = 1'b0;
        rd_d      = 1'b0;
        rd_addr_d = '0;
        rd_val_d  = '0;
        case (state_q)
            S_IDLE: begin
                if (start_in && !flush_in) begin
                    op_d    = op_in;
                    rd_en_d = rd_in;
                    addr_d  = rd_addr_in;
                    neg_d   = neg_in;
                    opnd_d  = is_div ? mag_b : mag_a;
                    acc_d   = {{XLEN{1'b0}}, (is_div ? mag_a : mag_b)};
                    cnt_d   = '0;
                    if (div_zero || div_ovf) begin
                        state_d   = S_DONE;
                        done_d    = 1'b1;
                        rd_d      = rd_in;
                        rd_addr_d = rd_addr_in;
                        rd_val_d  = early_val;
                    end else begin
                        state_d = S_CALC;
                    end
                end
            end
            S_CALC: begin
                if (flush_in) begin
                    state_d = S_IDLE;
                end else begin
                    acc_d = acc_nx;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CW'(XLEN-1)) begin
                        state_d   = S_DONE;
                        done_d    = 1'b1;
                        rd_d      = rd_en_q;
                        rd_addr_d = addr_q;
                        rd_val_d  = final_val;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            op_q      <= '0;
            rd_en_q   <= 1'b0;
            addr_q    <= '0;
            neg_q     <= 1'b0;
            opnd_q    <= '0;
            acc_q     <= '0;
            done_q    <= 1'b0;
            rd_q      <= 1'b0;
            rd_addr_q <= '0;
            rd_val_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            rd_en_q   <= rd_en_d;
            addr_q    <= addr_d;
            neg_q     <= neg_d;
            opnd_q    <= opnd_d;
            acc_q     <= acc_d;
            done_q    <= done_d;
            rd_q      <= rd_d;
            rd_addr_q <= rd_addr_d;
            rd_val_q  <= rd_val_d;
        end
    end

    assign stallreq_out = ((state_q == S_IDLE) && start_in && !flush_in) || (state_q == S_CALC);
    assign done_out     = done_q;
    assign rd_out       = rd_q;
    assign rd_addr_out  = rd_addr_q;
    assign rd_val_out   = rd_val_q;
endmodule

// File: tb/tb_ex_muldiv.sv
// Bench for ex_muldiv: directed and random ops against a 64-bit arithmetic reference model.
module tb_ex_muldiv;
    localparam int XLEN = 32;
    localparam logic [31:0] MIN_NEG = 32'h8000_0000;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b1;
    logic        start_in = 1'b0;
    logic [2:0]  op_in = '0;
    logic [31:0] rs1_val_in = '0;
    logic [31:0] rs2_val_in = '0;
    logic        rd_in = 1'b0;
    logic [4:0]  rd_addr_in = '0;
    logic        flush_in = 1'b0;
    logic        stallreq_out, done_out, rd_out;
    logic [4:0]  rd_addr_out;
    logic [31:0] rd_val_out;

    int n_chk = 0;
    int n_err = 0;

    ex_muldiv #(.XLEN(XLEN), .REG_ADDR_W(5)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .start_in(start_in), .op_in(op_in),
        .rs1_val_in(rs1_val_in), .rs2_val_in(rs2_val_in), .rd_in(rd_in),
        .rd_addr_in(rd_addr_in), .flush_in(flush_in), .stallreq_out(stallreq_out),
        .done_out(done_out), .rd_out(rd_out), .rd_addr_out(rd_addr_out),
        .rd_val_out(rd_val_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_res(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sb, p;
        logic [63:0] pu;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        p  = '0;
        pu = '0;
        case (op)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * $signed({32'd0, b}); return p[63:32]; end
            3'd3: begin pu = {32'd0, a} * {32'd0, b}; return pu[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == MIN_NEG && b == 32'hFFFF_FFFF) return MIN_NEG;
                p = sa / sb;
                return p[31:0];
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                p = sa % sb;
                return p[31:0];
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int ref_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        if (op[2] && b == 0) return 1;
        if ((op == 3'd4 || op == 3'd6) && a == MIN_NEG && b == 32'hFFFF_FFFF) return 1;
        return XLEN + 1;
    endfunction

    // Called #1 after a rising edge with the unit in IDLE; this cycle is cycle 0.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic rde, input logic [4:0] addr);
        logic [31:0] exp_val;
        int exp_l, cyc, bad_stall;
        bit got;
        exp_val = ref_res(op, a, b);
        exp_l   = ref_lat(op, a, b);
        start_in = 1'b1; op_in = op; rs1_val_in = a; rs2_val_in = b; rd_in = rde; rd_addr_in = addr;
        @(negedge clk_in);
        check("stall_c0", stallreq_out, 1);
        check("idle_done", done_out, 0);
        @(posedge clk_in); #1;
        start_in = 1'b0;
        rs1_val_in = $urandom; rs2_val_in = $urandom; op_in = 3'($urandom); rd_in = ~rde; rd_addr_in = ~addr;
        cyc = 1; got = 0; bad_stall = 0;
        while (cyc < 100 && !got) begin
            @(negedge clk_in);
            if (done_out) begin
                got = 1;
                check("latency", cyc, exp_l);
                check("rd_val", rd_val_out, exp_val);
                check("rd_out", rd_out, rde);
                check("rd_addr", rd_addr_out, addr);
                check("stall_done", stallreq_out, 0);
            end else if (stallreq_out !== 1'b1) begin
                bad_stall++;
            end
            @(posedge clk_in); #1;
            cyc++;
        end
        if (!got) check("timeout", 0, 1);
        check("stall_calc", bad_stall, 0);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return MIN_NEG;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #2;
        check("rst_done", done_out, 0);
        check("rst_rd", rd_out, 0);
        check("rst_addr", rd_addr_out, 0);
        check("rst_val", rd_val_out, 0);
        check("rst_stall", stallreq_out, 0);
        @(posedge clk_in); #1;
        rst_in = 1'b0;
        @(posedge clk_in); #1;

        run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 1'b1, 5'd3);
        run_op(3'd1, MIN_NEG, MIN_NEG, 1'b1, 5'd4);
        run_op(3'd2, MIN_NEG, MIN_NEG, 1'b1, 5'd5);
        run_op(3'd3, MIN_NEG, MIN_NEG, 1'b0, 5'd6);
        run_op(3'd0, MIN_NEG, MIN_NEG, 1'b1, 5'd7);
        run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 1'b1, 5'd8);
        run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 1'b1, 5'd9);
        run_op(3'd5, 32'd100, 32'd7, 1'b1, 5'd10);
        run_op(3'd7, 32'd100, 32'd7, 1'b1, 5'd11);
        run_op(3'd5, 32'h1234, 32'd0, 1'b1, 5'd12);
        run_op(3'd6, 32'h1234, 32'd0, 1'b1, 5'd13);
        run_op(3'd4, MIN_NEG, 32'hFFFF_FFFF, 1'b1, 5'd14);
        run_op(3'd6, MIN_NEG, 32'hFFFF_FFFF, 1'b1, 5'd15);

        // flush in IDLE blocks acceptance
        start_in = 1'b1; flush_in = 1'b1; op_in = 3'd0; rs1_val_in = 32'd3; rs2_val_in = 32'd3;
        @(negedge clk_in);
        check("flush_idle_stall", stallreq_out, 0);
        @(posedge clk_in); #1;
        start_in = 1'b0; flush_in = 1'b0;
        @(negedge clk_in);
        check("flush_idle_nostart", stallreq_out, 0);
        @(posedge clk_in); #1;

        // flush mid-divide in cycle 10
        begin
            int seen;
            seen = 0;
            start_in = 1'b1; op_in = 3'd4; rs1_val_in = 32'd1000; rs2_val_in = 32'd3; rd_in = 1'b1; rd_addr_in = 5'd1;
            @(posedge clk_in); #1;
            start_in = 1'b0;
            for (int c = 1; c < 10; c++) begin
                @(negedge clk_in);
                if (done_out) seen++;
                @(posedge clk_in); #1;
            end
            flush_in = 1'b1;
            @(posedge clk_in); #1;
            flush_in = 1'b0;
            @(negedge clk_in);
            check("flush_stall", stallreq_out, 0);
            check("flush_done", done_out, 0);
            check("flush_nopulse", seen, 0);
            @(posedge clk_in); #1;
        end
        run_op(3'd0, 32'h0001_2345, 32'h0000_0ABC, 1'b1, 5'd2);

        // asynchronous reset mid-CALC
        start_in = 1'b1; op_in = 3'd3; rs1_val_in = 32'hDEAD_BEEF; rs2_val_in = 32'h1234_5678;
        @(posedge clk_in); #1;
        start_in = 1'b0;
        repeat (5) @(posedge clk_in);
        #3 rst_in = 1'b1;
        #1;
        check("arst_stall", stallreq_out, 0);
        check("arst_done", done_out, 0);
        check("arst_val", rd_val_out, 0);
        check("arst_addr", rd_addr_out, 0);
        @(posedge clk_in); #1;
        rst_in = 1'b0;
        @(posedge clk_in); #1;
        run_op(3'd3, 32'hDEAD_BEEF, 32'h1234_5678, 1'b1, 5'd20);

        for (int i = 0; i < 50; i++)
            run_op(3'($urandom_range(0, 7)), pick(), pick(), 1'($urandom), 5'($urandom));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
